// File: rtl/decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe
//
// Registered RV32I decode stage between fetch and execute. Reads an internal
// register file, builds the sign-extended immediate and holds the decoded
// instruction in an ID/EX register. Inserts bubbles on load-use hazards
// against the load held in ID/EX. Supports flush and a sticky halt.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer. o_if_ready is combinational.
//
// Configuration macro: DECODE_WB_BYPASS_EN
//   defined   : a same-cycle writeback to rs1/rs2 (rs != x0) is forwarded
//               into the captured o_rs1_data/o_rs2_data.
//   undefined : captured data is the pre-write register file value.
//
// Parameters
//   XLEN          datapath width (register data, PC, immediate)
//   RF_DEPTH      architectural registers (32 = RV32I, 16 = RV32E)
//   LOAD_USE_GAP  bubbles inserted per load-use hazard (1..7)
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_if_valid/o_if_ready   fetch handshake, payload i_instr/i_pc
//   i_flush                 kill ID/EX contents and pending stall
//   i_wb_wen/addr/data      register file write port
//   o_ex_valid/i_ex_ready   execute handshake
//   o_pc .. o_funct7        registered decoded fields
//   o_halt                  sticky, set after ECALL/EBREAK is accepted
// -----------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int RF_DEPTH     = 32,
    parameter int LOAD_USE_GAP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_wen,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_immed,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_wen,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic            o_halt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [5:0] DEPTH     = 6'(RF_DEPTH);
    localparam logic [2:0] GAP_RELOAD = 3'(LOAD_USE_GAP - 1);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
    } fmt_e;

    // ---------------------------------------------------------------- state
    logic [XLEN-1:0] rf_q [32];  // entries >= RF_DEPTH are never written
    logic            ex_valid_q, ex_valid_d;
    logic [2:0]      stall_cnt_q, stall_cnt_d;
    logic            halt_q, halt_d;
    logic            load_en;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, immed_q;
    logic [4:0]      rd_addr_q;
    logic            rd_wen_q;
    logic [6:0]      opcode_q, funct7_q;
    logic [2:0]      funct3_q;

    // --------------------------------------------------------------- decode
    logic [6:0]      dec_op;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    fmt_e            dec_fmt;
    logic [31:0]     imm32;
    logic [XLEN-1:0] immed_d;
    logic            rd_wen_d;
    logic            uses_rs2;

    assign dec_op  = i_instr[6:0];
    assign dec_rd  = i_instr[11:7];
    assign dec_rs1 = i_instr[19:15];
    assign dec_rs2 = i_instr[24:20];

    always_comb begin
        dec_fmt = FMT_X;
        case (dec_op)
            OP_OP:                                    dec_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_MISC,
            OP_SYSTEM:                                dec_fmt = FMT_I;
            OP_STORE:                                 dec_fmt = FMT_S;
            OP_BRANCH:                                dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                         dec_fmt = FMT_U;
            OP_JAL:                                   dec_fmt = FMT_J;
            default:                                  dec_fmt = FMT_X;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: imm32 = {i_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign immed_d  = XLEN'($signed(imm32));
    assign rd_wen_d = (dec_fmt == FMT_R || dec_fmt == FMT_I ||
                       dec_fmt == FMT_U || dec_fmt == FMT_J) && (dec_rd != 5'd0);
    assign uses_rs2 = (dec_fmt == FMT_R || dec_fmt == FMT_S || dec_fmt == FMT_B);

    // -------------------------------------------------------- register file
    logic            wb_ok;
    logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_val, rs2_val;

    assign wb_ok  = i_wb_wen && (i_wb_addr != 5'd0) && ({1'b0, i_wb_addr} < DEPTH);
    assign rs1_rf = (dec_rs1 != 5'd0 && {1'b0, dec_rs1} < DEPTH) ? rf_q[dec_rs1] : '0;
    assign rs2_rf = (dec_rs2 != 5'd0 && {1'b0, dec_rs2} < DEPTH) ? rf_q[dec_rs2] : '0;

`ifdef DECODE_WB_BYPASS_EN
    // Forward a write landing on the same edge as the capture.
    assign rs1_val = (wb_ok && i_wb_addr == dec_rs1) ? i_wb_data : rs1_rf;
    assign rs2_val = (wb_ok && i_wb_addr == dec_rs2) ? i_wb_data : rs2_rf;
`else
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    // ------------------------------------------------- hazard and handshake
    logic hazard, accept;

    // Incoming instruction reads the destination of the load still in ID/EX.
    assign hazard = ex_valid_q && (opcode_q == OP_LOAD) && rd_wen_q && i_if_valid &&
                    ((rd_addr_q == dec_rs1) || (uses_rs2 && rd_addr_q == dec_rs2));

    assign o_if_ready = !i_rst && !halt_q && (stall_cnt_q == 3'd0) && !hazard &&
                        (!ex_valid_q || i_ex_ready);
    assign accept = i_if_valid && o_if_ready;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        halt_d      = halt_q;
        load_en     = 1'b0;
        if (stall_cnt_q != 3'd0) stall_cnt_d = stall_cnt_q - 3'd1;
        if (i_flush) begin
            // Flush wins over a simultaneous accept: the instruction is dropped.
            ex_valid_d  = 1'b0;
            stall_cnt_d = 3'd0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            load_en    = 1'b1;
            if (dec_op == OP_SYSTEM) halt_d = 1'b1;
        end else if (i_ex_ready) begin
            ex_valid_d = 1'b0;
            // The load drains now; remaining bubbles are counted down here.
            if (hazard) stall_cnt_d = GAP_RELOAD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= 3'd0;
            halt_q      <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            immed_q     <= '0;
            rd_addr_q   <= '0;
            rd_wen_q    <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            halt_q      <= halt_d;
            if (load_en) begin
                pc_q       <= i_pc;
                rs1_data_q <= rs1_val;
                rs2_data_q <= rs2_val;
                immed_q    <= immed_d;
                rd_addr_q  <= dec_rd;
                rd_wen_q   <= rd_wen_d;
                opcode_q   <= dec_op;
                funct3_q   <= i_instr[14:12];
                funct7_q   <= i_instr[31:25];
            end
            if (wb_ok) rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    assign o_ex_valid = ex_valid_q;
    assign o_pc       = pc_q;
    assign o_rs1_data = rs1_data_q;
    assign o_rs2_data = rs2_data_q;
    assign o_immed    = immed_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_rd_wen   = rd_wen_q;
    assign o_opcode   = opcode_q;
    assign o_funct3   = funct3_q;
    assign o_funct7   = funct7_q;
    assign o_halt     = halt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// Bench for decode_stage_pipe. Instance u_a uses the default configuration
// (RF_DEPTH 32, LOAD_USE_GAP 1); instance u_b (RF_DEPTH 16, LOAD_USE_GAP 3)
// shares the same stimulus and is checked in the tests that target it.
// -----------------------------------------------------------------------------
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_X = 6;

    logic        rst, if_valid, flush, wb_wen, ex_ready;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;

    logic        a_if_ready, a_ex_valid, a_wen, a_halt;
    logic [31:0] a_pc, a_rs1, a_rs2, a_imm;
    logic [4:0]  a_rd;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3;
    logic        b_if_ready, b_ex_valid, b_wen, b_halt;
    logic [31:0] b_pc, b_rs1, b_rs2, b_imm;
    logic [4:0]  b_rd;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;
    logic [150:0] a_fields, b_fields;

    assign a_fields = {a_pc, a_rs1, a_rs2, a_imm, a_rd, a_wen, a_op, a_f3, a_f7};
    assign b_fields = {b_pc, b_rs1, b_rs2, b_imm, b_rd, b_wen, b_op, b_f3, b_f7};

    int tests_run    = 0;
    int tests_failed = 0;

    decode_stage_pipe #(.XLEN(32), .RF_DEPTH(32), .LOAD_USE_GAP(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(a_if_ready),
        .i_instr(instr), .i_pc(pc), .i_flush(flush), .i_wb_wen(wb_wen),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_ex_valid(a_ex_valid),
        .i_ex_ready(ex_ready), .o_pc(a_pc), .o_rs1_data(a_rs1), .o_rs2_data(a_rs2),
        .o_immed(a_imm), .o_rd_addr(a_rd), .o_rd_wen(a_wen), .o_opcode(a_op),
        .o_funct3(a_f3), .o_funct7(a_f7), .o_halt(a_halt)
    );

    decode_stage_pipe #(.XLEN(32), .RF_DEPTH(16), .LOAD_USE_GAP(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .o_if_ready(b_if_ready),
        .i_instr(instr), .i_pc(pc), .i_flush(flush), .i_wb_wen(wb_wen),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_ex_valid(b_ex_valid),
        .i_ex_ready(ex_ready), .o_pc(b_pc), .o_rs1_data(b_rs1), .o_rs2_data(b_rs2),
        .o_immed(b_imm), .o_rd_addr(b_rd), .o_rd_wen(b_wen), .o_opcode(b_op),
        .o_funct3(b_f3), .o_funct7(b_f7), .o_halt(b_halt)
    );

    // ------------------------------------------------------------ encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[31:12], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    // ------------------------------------------------------ reference model
    function automatic int ref_fmt(input logic [6:0] op);
        case (op)
            7'h33:                             return F_R;
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return F_I;
            7'h23:                             return F_S;
            7'h63:                             return F_B;
            7'h37, 7'h17:                      return F_U;
            7'h6F:                             return F_J;
            default:                           return F_X;
        endcase
    endfunction

    // Immediate value reconstructed with signed integer arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int s, hi;
        s  = int'(ins);
        hi = s >>> 31;
        case (ref_fmt(ins[6:0]))
            F_I: return 32'(s >>> 20);
            F_S: return 32'((s >>> 25) * 32 + int'(ins[11:7]));
            F_B: return 32'(hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                            int'(ins[11:8]) * 2);
            F_U: return ins & 32'hFFFFF000;
            F_J: return 32'(hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                            int'(ins[30:21]) * 2);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_wen(input logic [31:0] ins);
        int f;
        f = ref_fmt(ins[6:0]);
        return (f == F_R || f == F_I || f == F_U || f == F_J) && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs1, rs2, rd;
        logic [31:0] r;
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        r   = $urandom;
        case ($urandom_range(0, 8))
            0: return enc_r(r[0] ? 7'h20 : 7'h00, rs2, rs1, r[3:1], rd);
            1: return enc_i(int'(r), rs1, r[14:12], rd, 7'h13);
            2, 3: return enc_i(int'(r), rs1, 3'd2, rd, 7'h03);
            4: return enc_s(int'(r), rs2, rs1, 3'd2);
            5: return enc_b(int'(r), rs2, rs1, r[14:12]);
            6: return enc_u(int'(r), rd, r[0] ? 7'h37 : 7'h17);
            7: return enc_j(int'(r), rd);
            default: return {r[31:7], 7'b0101011};
        endcase
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        if_valid = 1'b0;
        flush    = 1'b0;
        wb_wen   = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        ex_ready = 1'b1;
        instr    = 32'd0;
        pc       = 32'd0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        if_valid = 1'b1;
        instr = enc_i(-3, 0, 0, 5, 7'h13);
        @(negedge clk);
        tests_run++;
        if (a_if_ready !== 1'b0 || b_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready got a=%b b=%b exp 0", a_if_ready, b_if_ready);
        end
        tick();
        tests_run++;
        if (a_ex_valid !== 1'b0 || a_halt !== 1'b0 || a_fields !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got valid=%b halt=%b fields=%h exp all 0",
                     a_ex_valid, a_halt, a_fields);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready got %b exp 1", a_if_ready);
        end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        do_reset();
        if_valid = 1'b1;
        instr = enc_i(-3, 0, 0, 5, 7'h13);
        pc = 32'h100;
        @(negedge clk);
        tests_run++;
        if (a_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL addi_ready got %b exp 1", a_if_ready);
        end
        tick();
        if_valid = 1'b0;
        tests_run++;
        if (a_ex_valid !== 1'b1 || a_imm !== 32'hFFFFFFFD || a_rd !== 5'd5 ||
            a_wen !== 1'b1 || a_pc !== 32'h100 || a_op !== 7'h13 || a_rs1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL addi_fields got v=%b imm=%h rd=%0d wen=%b pc=%h op=%h rs1=%h exp 1 fffffffd 5 1 100 13 0",
                     a_ex_valid, a_imm, a_rd, a_wen, a_pc, a_op, a_rs1);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        if_valid = 1'b1;
        instr = enc_i(0, 1, 3'd2, 6, 7'h03);
        pc = 32'h200;
        tick();
        tests_run++;
        if (a_ex_valid !== 1'b1 || a_op !== 7'h03 || a_rd !== 5'd6 || a_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_capture got v=%b op=%h rd=%0d wen=%b", a_ex_valid, a_op, a_rd, a_wen);
        end
        // Store reads x6 through rs2 -> hazard; ADDI with instr[24:20]=6 does not.
        instr = enc_s(0, 6, 1, 3'd2);
        @(negedge clk);
        tests_run++;
        if (a_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_rs2_hazard got ready=%b exp 0", a_if_ready);
        end
        instr = enc_i(6, 1, 0, 9, 7'h13);
        #1;
        tests_run++;
        if (a_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL addi_no_rs2 got ready=%b exp 1", a_if_ready);
        end
        instr = enc_r(7'h00, 2, 6, 0, 7);
        pc = 32'h204;
        #1;
        tests_run++;
        if (a_if_ready !== 1'b0 || b_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_hazard got a=%b b=%b exp 0 0", a_if_ready, b_if_ready);
        end
        tick();
        tests_run++;
        if (a_ex_valid !== 1'b0 || b_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble1 got a=%b b=%b exp 0 0", a_ex_valid, b_ex_valid);
        end
        @(negedge clk);
        tests_run++;
        if (a_if_ready !== 1'b1 || b_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_ready1 got a=%b b=%b exp 1 0", a_if_ready, b_if_ready);
        end
        tick();
        tests_run++;
        if (a_ex_valid !== 1'b1 || a_op !== 7'h33 || a_rd !== 5'd7 || a_pc !== 32'h204 ||
            b_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_issue got a_v=%b op=%h rd=%0d pc=%h b_v=%b",
                     a_ex_valid, a_op, a_rd, a_pc, b_ex_valid);
        end
        @(negedge clk);
        tests_run++;
        if (b_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_ready2 got b=%b exp 0", b_if_ready);
        end
        tick();
        tests_run++;
        if (b_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble3 got b=%b exp 0", b_ex_valid);
        end
        @(negedge clk);
        tests_run++;
        if (b_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_end_ready got b=%b exp 1", b_if_ready);
        end
        tick();
        if_valid = 1'b0;
        tests_run++;
        if (b_ex_valid !== 1'b1 || b_op !== 7'h33 || b_rd !== 5'd7) begin
            tests_failed++;
            $display("FAIL gap3_issue got v=%b op=%h rd=%0d exp 1 33 7", b_ex_valid, b_op, b_rd);
        end
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        if_valid = 1'b1;
        instr = enc_b(-8, 2, 1, 3'd0);
        pc = 32'h300;
        tick();
        ex_ready = 1'b0;
        instr = enc_i(1, 0, 0, 3, 7'h13);
        pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (a_if_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_ready cyc=%0d got %b exp 0", i, a_if_ready);
            end
            tick();
            tests_run++;
            if (a_ex_valid !== 1'b1 || a_imm !== 32'hFFFFFFF8 || a_wen !== 1'b0 ||
                a_pc !== 32'h300 || a_op !== 7'h63) begin
                tests_failed++;
                $display("FAIL hold_fields cyc=%0d got v=%b imm=%h wen=%b pc=%h op=%h exp 1 fffffff8 0 300 63",
                         i, a_ex_valid, a_imm, a_wen, a_pc, a_op);
            end
        end
        if_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        tests_run++;
        if (a_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_drain got %b exp 0", a_ex_valid);
        end
    endtask

    task automatic test_wb_same_cycle();
        do_reset();
        wb_wen = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h1234;
        if_valid = 1'b1;
        instr = enc_r(7'h00, 0, 3, 0, 4);
        tick();
        tests_run++;
        if (a_rs1 !== (BYPASS ? 32'h1234 : 32'h0)) begin
            tests_failed++;
            $display("FAIL wb_same_cycle got %h exp %h", a_rs1, BYPASS ? 32'h1234 : 32'h0);
        end
        wb_addr = 5'd0;
        wb_data = 32'hFFFF;
        tick();
        wb_wen = 1'b0;
        tests_run++;
        if (a_rs1 !== 32'h1234) begin
            tests_failed++;
            $display("FAIL wb_later got %h exp 00001234", a_rs1);
        end
        instr = enc_r(7'h00, 3, 0, 0, 4);
        tick();
        if_valid = 1'b0;
        tests_run++;
        if (a_rs1 !== 32'h0 || a_rs2 !== 32'h1234) begin
            tests_failed++;
            $display("FAIL x0_write got rs1=%h rs2=%h exp 0 1234", a_rs1, a_rs2);
        end
        tick();
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        if_valid = 1'b1;
        instr = enc_s(4, 2, 1, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (a_ex_valid !== 1'b0 || b_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_drop got a=%b b=%b exp 0 0", a_ex_valid, b_ex_valid);
        end
        instr = enc_i(0, 1, 3'd2, 6, 7'h03);
        pc = 32'h400;
        tick();
        instr = enc_r(7'h00, 2, 6, 0, 7);
        pc = 32'h404;
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (b_if_ready !== 1'b0 || a_if_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_ready got a=%b b=%b exp 0 0", a_if_ready, b_if_ready);
        end
        tick();
        tests_run++;
        if (b_ex_valid !== 1'b0 || b_halt !== 1'b0 || b_fields !== '0) begin
            tests_failed++;
            $display("FAIL midstall_reset got v=%b halt=%b fields=%h exp 0", b_ex_valid, b_halt, b_fields);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_cleared got %b exp 1", b_if_ready);
        end
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        if_valid = 1'b1;
        instr = 32'h00000073;
        pc = 32'h500;
        tick();
        tests_run++;
        if (a_halt !== 1'b1 || a_ex_valid !== 1'b1 || a_op !== 7'h73) begin
            tests_failed++;
            $display("FAIL ecall got halt=%b v=%b op=%h exp 1 1 73", a_halt, a_ex_valid, a_op);
        end
        instr = enc_i(1, 0, 0, 3, 7'h13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (a_if_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL halt_ready cyc=%0d got %b exp 0", i, a_if_ready);
            end
            tick();
            tests_run++;
            if (a_ex_valid !== 1'b0 || a_halt !== 1'b1) begin
                tests_failed++;
                $display("FAIL halt_drain cyc=%0d got v=%b halt=%b exp 0 1", i, a_ex_valid, a_halt);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (a_halt !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_flush got %b exp 1", a_halt);
        end
        do_reset();
        tests_run++;
        if (a_halt !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_reset got %b exp 0", a_halt);
        end
    endtask

    task automatic test_rf_depth();
        do_reset();
        wb_wen = 1'b1;
        wb_addr = 5'd20;
        wb_data = 32'hDEAD;
        tick();
        wb_addr = 5'd9;
        wb_data = 32'hBEEF;
        tick();
        wb_wen = 1'b0;
        if_valid = 1'b1;
        instr = enc_r(7'h00, 9, 20, 0, 1);
        tick();
        if_valid = 1'b0;
        tests_run++;
        if (b_rs1 !== 32'h0 || b_rs2 !== 32'hBEEF) begin
            tests_failed++;
            $display("FAIL rf16_read got rs1=%h rs2=%h exp 0 beef", b_rs1, b_rs2);
        end
        tests_run++;
        if (a_rs1 !== 32'hDEAD || a_rs2 !== 32'hBEEF) begin
            tests_failed++;
            $display("FAIL rf32_read got rs1=%h rs2=%h exp dead beef", a_rs1, a_rs2);
        end
        tick();
    endtask

    // Random traffic on u_a against a transaction-level model.
    task automatic test_random();
        logic        m_valid, m_halt, haz, rdy, uses2;
        int          m_stall;
        logic [31:0] m_ins, m_pc, m_rs1, m_rs2, m_rf[32];
        logic [150:0] exp_f;
        int          f;
        do_reset();
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_stall = 0;
        m_ins   = 32'd0;
        m_pc    = 32'd0;
        m_rs1   = 32'd0;
        m_rs2   = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tests_run++;
            if (a_ex_valid !== m_valid || a_halt !== m_halt) begin
                tests_failed++;
                $display("FAIL rnd_valid cyc=%0d got v=%b h=%b exp v=%b h=%b",
                         cyc, a_ex_valid, a_halt, m_valid, m_halt);
            end
            if (m_valid) begin
                exp_f = {m_pc, m_rs1, m_rs2, ref_imm(m_ins), m_ins[11:7], ref_wen(m_ins),
                         m_ins[6:0], m_ins[14:12], m_ins[31:25]};
                tests_run++;
                if (a_fields !== exp_f) begin
                    tests_failed++;
                    $display("FAIL rnd_fields cyc=%0d got %h exp %h", cyc, a_fields, exp_f);
                end
            end
            if_valid = ($urandom_range(0, 3) != 0);
            instr    = rand_instr();
            pc       = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            wb_wen   = ($urandom_range(0, 1) == 1);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            @(negedge clk);
            f     = ref_fmt(instr[6:0]);
            uses2 = (f == F_R || f == F_S || f == F_B);
            haz   = m_valid && m_ins[6:0] == 7'h03 && ref_wen(m_ins) && if_valid &&
                    (m_ins[11:7] == instr[19:15] || (uses2 && m_ins[11:7] == instr[24:20]));
            rdy   = !m_halt && m_stall == 0 && !haz && (!m_valid || ex_ready);
            tests_run++;
            if (a_if_ready !== rdy) begin
                tests_failed++;
                $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, a_if_ready, rdy);
            end
            if (flush) begin
                m_valid = 1'b0;
                m_stall = 0;
            end else if (if_valid && rdy) begin
                m_valid = 1'b1;
                m_ins   = instr;
                m_pc    = pc;
                m_rs1   = (instr[19:15] == 0) ? 32'd0 : m_rf[instr[19:15]];
                m_rs2   = (instr[24:20] == 0) ? 32'd0 : m_rf[instr[24:20]];
                if (BYPASS && wb_wen && wb_addr != 0 && wb_addr == instr[19:15]) m_rs1 = wb_data;
                if (BYPASS && wb_wen && wb_addr != 0 && wb_addr == instr[24:20]) m_rs2 = wb_data;
                if (instr[6:0] == 7'h73) m_halt = 1'b1;
            end else begin
                if (m_stall > 0) m_stall--;
                if (ex_ready) begin
                    m_valid = 1'b0;
                    if (haz) m_stall = 0;  // one bubble for LOAD_USE_GAP=1: the drain itself
                end
            end
            if (wb_wen && wb_addr != 0) m_rf[wb_addr] = wb_data;
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_addi();
        test_load_use();
        test_hold();
        test_wb_same_cycle();
        test_flush_and_reset();
        test_halt();
        test_rf_depth();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        tests_failed++;
        $display("FAIL watchdog got timeout exp completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
